ram_slot_arbiter: RTL and testbench
===================================

Name: ram_slot_arbiter

Overview:
- Sequences the shared 32 KiB system RAM between three requesters: the CRTC/video fetch, the 6502, and the debugger memory-peek port.
- Each 2 MHz processor period holds two 4 MHz RAM slots: slot V (video) and slot C (CPU/debug).
- Drives one synchronous single-port RAM array and returns latched read data to each requester.
- Stretches the CPU (READY low) when a starved debug request must steal a C slot.

Parameters:
- ADR_W, 15, RAM address width (32 KiB).
- MAX_WAIT, 4, number of C slots a pending debug request may lose to the CPU before it steals one.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- RAM_en  in  1  4 MHz slot strobe, one CLK wide.
- PROC_en  in  1  2 MHz strobe; RAM_en&PROC_en marks slot V.
- vid_adr  in  15  video address, already CRTC-corrected.
- vid_data  out  8  latched video byte.
- cpu_cs  in  1  CPU addresses RAM (A15=0).
- cpu_rnw  in  1  CPU read/not-write.
- cpu_adr  in  15  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  latched CPU read byte.
- cpu_ready  out  1  0 = stretch CPU this slot.
- dbg_req  in  1  debug request, level, held until ack.
- dbg_rnw  in  1  debug read/not-write.
- dbg_adr  in  15  debug address.
- dbg_wdata  in  8  debug write data.
- dbg_rdata  out  8  latched debug read byte.
- dbg_ack  out  1  one-CLK pulse, access complete.
- ram_adr  out  15  RAM address.
- ram_we  out  1  RAM write strobe, one CLK.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the CLK after address (1-cycle synchronous read).

Behaviour:
- Reset values:
  - vid_data, cpu_rdata, dbg_rdata = 8'h00.
  - cpu_ready = 1; dbg_ack = 0; ram_we = 0; ram_adr = 0; ram_wdata = 0.
  - FSM = IDLE; wait counter = 0.
- FSM states: IDLE, VID_RD, CPU_RD, CPU_WR, DBG_RD, DBG_WR, CAPTURE.
- From IDLE on RAM_en:
  - PROC_en=1 (slot V): go to VID_RD, ram_adr = vid_adr.
  - PROC_en=0 (slot C): grant per the arbitration rules below.
- VID_RD, CPU_RD, DBG_RD: always go to CAPTURE on the next CLK. CAPTURE latches ram_rdata into the owner's register, then returns to IDLE.
  - Latency: slot strobe to data latched = 2 CLK.
- CPU_WR, DBG_WR: ram_we=1 for exactly the CLK after the slot strobe, then IDLE. DBG_WR pulses dbg_ack in that same CLK.
- Slot C arbitration, first match wins:
  1. dbg_req and wait counter == MAX_WAIT → debug granted. cpu_ready=0 for this slot; the CPU re-executes the cycle next period.
  2. cpu_cs → CPU granted. If dbg_req, wait counter +1 (saturating).
  3. dbg_req → debug granted.
  4. Otherwise idle; no RAM access.
- Wait counter clears on every debug grant and whenever dbg_req=0.
- cpu_ready:
  - Registered; changes only on a slot C strobe.
  - Driven low only in a stolen slot; returns to 1 at the next slot C.
  - Never low for two consecutive C slots: after a steal the counter is 0, so the CPU is always granted next.
- dbg_ack:
  - Pulses in CAPTURE for reads, in DBG_WR for writes.
  - dbg_req must drop within 1 CLK of ack, otherwise it is treated as a new request.
- Slot V always goes to video. CPU and debug never use slot V, even when video is unused.
- A RAM_en arriving in a non-IDLE state is a protocol error. It is ignored (assertion in simulation).
- cpu_rdata holds its value when the CPU has no read grant. vid_data holds between V slots.
- Reset mid-access: all state returns to reset values immediately. ram_we drops asynchronously and no partial write completes after reset deasserts.

Decomposition:
- Shared package holds:
  - FSM state encoding (3 bits).
  - Owner encoding: OWN_VID, OWN_CPU, OWN_DBG.
  - KiB32 / ADR_W constants, reused by the top level.
- One sub-module, `starve_counter`: saturating counter with clear, width $clog2(MAX_WAIT+1). It drives the steal decision.

Test Plan:
- Video only, vid_adr=15'h7C00, RAM[7C00]=8'hA5 → vid_data=8'hA5 two CLK after slot V strobe; ram_we never asserts.
- CPU write cpu_adr=15'h0123, cpu_wdata=8'h5A in slot C, then read → one ram_we pulse at 15'h0123; cpu_rdata=8'h5A two CLK after the read slot strobe.
- Debug read of 15'h1000 (=8'h3C) with cpu_cs=0 → granted in first C slot; dbg_ack one pulse; dbg_rdata=8'h3C; cpu_ready stays 1.
- Debug request with cpu_cs=1 continuously, MAX_WAIT=4 → CPU wins four C slots; 5th C slot stolen, with cpu_ready=0 for that slot only and dbg_ack issued; next C slot goes to CPU.
- Simultaneous video slot and pending debug → slot V serves video, debug served in the following slot C; vid_data correct.
- RESET asserted the CLK after a CPU_WR strobe → ram_we=0 immediately, all outputs at reset values, FSM IDLE, RAM location unchanged.

Source files
------------

// File: rtl/ram_slot_arbiter_pkg.sv
// ============================================================================
//  Module   : ram_slot_arbiter_pkg
//  Purpose  : Shared types and constants for the RAM slot arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_slot_arbiter_pkg;

  localparam int RAM_KIB32  = 32768;
  localparam int RAM_ADR_W  = $clog2(RAM_KIB32);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID_RD  = 3'd1,
    ST_CPU_RD  = 3'd2,
    ST_CPU_WR  = 3'd3,
    ST_DBG_RD  = 3'd4,
    ST_DBG_WR  = 3'd5,
    ST_CAPTURE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DBG = 2'd2
  } owner_t;

  function automatic logic is_slot_c(input logic ram_en, input logic proc_en);
    return ram_en & ~proc_en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_slot_arbiter_if.sv
// ============================================================================
//  Module   : ram_slot_arbiter_if
//  Purpose  : Requester, strobe and RAM-array signals of the slot arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_slot_arbiter_if #(
  parameter int ADR_W = ram_slot_arbiter_pkg::RAM_ADR_W
);
  logic             RAM_en;
  logic             PROC_en;
  logic [ADR_W-1:0] vid_adr;
  logic [7:0]       vid_data;
  logic             cpu_cs;
  logic             cpu_rnw;
  logic [ADR_W-1:0] cpu_adr;
  logic [7:0]       cpu_wdata;
  logic [7:0]       cpu_rdata;
  logic             cpu_ready;
  logic             dbg_req;
  logic             dbg_rnw;
  logic [ADR_W-1:0] dbg_adr;
  logic [7:0]       dbg_wdata;
  logic [7:0]       dbg_rdata;
  logic             dbg_ack;
  logic [ADR_W-1:0] ram_adr;
  logic             ram_we;
  logic [7:0]       ram_wdata;
  logic [7:0]       ram_rdata;

  // Requesters and RAM model side
  modport master (
    output RAM_en, PROC_en, vid_adr, cpu_cs, cpu_rnw, cpu_adr, cpu_wdata,
           dbg_req, dbg_rnw, dbg_adr, dbg_wdata, ram_rdata,
    input  vid_data, cpu_rdata, cpu_ready, dbg_rdata, dbg_ack,
           ram_adr, ram_we, ram_wdata
  );

  // Arbiter side
  modport slave (
    input  RAM_en, PROC_en, vid_adr, cpu_cs, cpu_rnw, cpu_adr, cpu_wdata,
           dbg_req, dbg_rnw, dbg_adr, dbg_wdata, ram_rdata,
    output vid_data, cpu_rdata, cpu_ready, dbg_rdata, dbg_ack,
           ram_adr, ram_we, ram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/ram_slot_arbiter_starve_counter.sv
// ============================================================================
//  Module   : starve_counter
//  Purpose  : Counts C slots a pending debug request has lost to the CPU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_at_max
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && (count_q != C_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_at_max = (count_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/ram_slot_arbiter.sv
// ============================================================================
//  Module   : ram_slot_arbiter
//  Purpose  : Shares one synchronous RAM between video, CPU and debug ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_slot_arbiter #(
  parameter int ADR_W    = ram_slot_arbiter_pkg::RAM_ADR_W,
  parameter int MAX_WAIT = 4
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  ram_slot_arbiter_if.slave  bus
);

  import ram_slot_arbiter_pkg::*;

  state_t           state_q,     state_d;
  owner_t           owner_q,     owner_d;
  logic [ADR_W-1:0] ram_adr_q,   ram_adr_d;
  logic             ram_we_q,    ram_we_d;
  logic [7:0]       ram_wdata_q, ram_wdata_d;
  logic [7:0]       vid_data_q,  vid_data_d;
  logic [7:0]       cpu_rdata_q, cpu_rdata_d;
  logic [7:0]       dbg_rdata_q, dbg_rdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             dbg_ack_q,   dbg_ack_d;

  logic slot_v;
  logic slot_c;
  logic dbg_grant;
  logic cpu_grant;
  logic cnt_inc;
  logic cnt_clr;
  logic steal_due;

  assign slot_v = bus.RAM_en & bus.PROC_en;
  assign slot_c = is_slot_c(bus.RAM_en, bus.PROC_en);

  // A starved request wins before the CPU; otherwise the CPU has priority.
  always_comb begin
    dbg_grant = 1'b0;
    cpu_grant = 1'b0;
    cnt_inc   = 1'b0;
    if ((state_q == ST_IDLE) && slot_c) begin
      if (bus.dbg_req && steal_due) begin
        dbg_grant = 1'b1;
      end else if (bus.cpu_cs) begin
        cpu_grant = 1'b1;
        cnt_inc   = bus.dbg_req;
      end else if (bus.dbg_req) begin
        dbg_grant = 1'b1;
      end
    end
  end

  assign cnt_clr = ~bus.dbg_req | dbg_grant;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (CLK),
    .rst      (RESET),
    .i_clr    (cnt_clr),
    .i_inc    (cnt_inc),
    .o_at_max (steal_due)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_adr_d   = ram_adr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ready_d = cpu_ready_q;
    dbg_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (slot_v) begin
          state_d   = ST_VID_RD;
          owner_d   = OWN_VID;
          ram_adr_d = bus.vid_adr;
        end else if (slot_c) begin
          // Stall the CPU only when its slot is taken away from it.
          cpu_ready_d = ~(dbg_grant & bus.cpu_cs);
          if (dbg_grant) begin
            owner_d   = OWN_DBG;
            ram_adr_d = bus.dbg_adr;
            if (bus.dbg_rnw) begin
              state_d = ST_DBG_RD;
            end else begin
              state_d     = ST_DBG_WR;
              ram_we_d    = 1'b1;
              ram_wdata_d = bus.dbg_wdata;
              dbg_ack_d   = 1'b1;
            end
          end else if (cpu_grant) begin
            owner_d   = OWN_CPU;
            ram_adr_d = bus.cpu_adr;
            if (bus.cpu_rnw) begin
              state_d = ST_CPU_RD;
            end else begin
              state_d     = ST_CPU_WR;
              ram_we_d    = 1'b1;
              ram_wdata_d = bus.cpu_wdata;
            end
          end
        end
      end
      ST_VID_RD, ST_CPU_RD: begin
        state_d = ST_CAPTURE;
      end
      ST_DBG_RD: begin
        state_d   = ST_CAPTURE;
        dbg_ack_d = 1'b1;
      end
      ST_CPU_WR, ST_DBG_WR: begin
        state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        case (owner_q)
          OWN_VID: vid_data_d  = bus.ram_rdata;
          OWN_CPU: cpu_rdata_d = bus.ram_rdata;
          OWN_DBG: dbg_rdata_d = bus.ram_rdata;
          default: vid_data_d  = vid_data_q;
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VID;
      ram_adr_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
      dbg_rdata_q <= 8'h00;
      cpu_ready_q <= 1'b1;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_adr_q   <= ram_adr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign bus.ram_adr   = ram_adr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dbg_ack   = dbg_ack_q;

  // Slot strobes must never overlap an access still in flight.
  a_strobe_only_in_idle: assert property (
    @(posedge CLK) disable iff (RESET) bus.RAM_en |-> (state_q == ST_IDLE)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_slot_arbiter.sv
// ============================================================================
//  Module   : tb_ram_slot_arbiter
//  Purpose  : Directed self-checking bench for ram_slot_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_slot_arbiter;

  import ram_slot_arbiter_pkg::*;

  typedef enum int {EX_NONE, EX_VID, EX_CPU_RD, EX_CPU_WR, EX_DBG_RD, EX_DBG_WR} ex_kind_e;

  typedef struct {
    string       tag;
    ex_kind_e    kind;
    logic [14:0] adr;
    logic [7:0]  data;
    logic        rdy;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  logic preload;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic [7:0] m_vid;
  logic [7:0] m_cpu;
  logic [7:0] m_dbg;
  logic       m_ready;

  logic [7:0] mem [0:RAM_KIB32-1];

  always #5 CLK = ~CLK;

  ram_slot_arbiter_if #(.ADR_W(RAM_ADR_W)) bus ();

  ram_slot_arbiter #(
    .ADR_W    (RAM_ADR_W),
    .MAX_WAIT (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Synchronous single-port RAM, one-cycle read latency
  always @(posedge CLK) begin
    if (preload) begin
      mem[15'h7C00] <= 8'hA5;
      mem[15'h1000] <= 8'h3C;
      mem[15'h0200] <= 8'h77;
    end else if (bus.ram_we) begin
      mem[bus.ram_adr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_adr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 4-CLK RAM slot; called at a negedge, returns at the next slot's negedge.
  task automatic slot(input bit is_v, input ex_kind_e kind, input logic [14:0] adr,
                      input logic [7:0] data, input logic rdy, input string tag);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.adr  = adr;
    e.data = data;
    e.rdy  = rdy;
    sb.push_back(e);
    bus.RAM_en  = 1'b1;
    bus.PROC_en = is_v;
    @(negedge CLK);
    bus.RAM_en  = 1'b0;
    bus.PROC_en = 1'b0;
    e = sb.pop_front();
    if (!is_v) m_ready = e.rdy;
    chk({e.tag, ".we"}, 32'(bus.ram_we), 32'(e.kind == EX_CPU_WR || e.kind == EX_DBG_WR));
    if (e.kind != EX_NONE) chk({e.tag, ".adr"}, 32'(bus.ram_adr), 32'(e.adr));
    if (e.kind == EX_CPU_WR || e.kind == EX_DBG_WR)
      chk({e.tag, ".wdata"}, 32'(bus.ram_wdata), 32'(e.data));
    chk({e.tag, ".ready"}, 32'(bus.cpu_ready), 32'(m_ready));
    chk({e.tag, ".ack1"}, 32'(bus.dbg_ack), 32'(e.kind == EX_DBG_WR));
    if (bus.dbg_ack) bus.dbg_req = 1'b0;
    @(negedge CLK);
    chk({e.tag, ".we2"}, 32'(bus.ram_we), 32'd0);
    chk({e.tag, ".ack2"}, 32'(bus.dbg_ack), 32'(e.kind == EX_DBG_RD));
    if (bus.dbg_ack) bus.dbg_req = 1'b0;
    @(negedge CLK);
    case (e.kind)
      EX_VID:    m_vid = e.data;
      EX_CPU_RD: m_cpu = e.data;
      EX_DBG_RD: m_dbg = e.data;
      default:   ;
    endcase
    chk({e.tag, ".vid_data"},  32'(bus.vid_data),  32'(m_vid));
    chk({e.tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'(m_cpu));
    chk({e.tag, ".dbg_rdata"}, 32'(bus.dbg_rdata), 32'(m_dbg));
    chk({e.tag, ".ack3"}, 32'(bus.dbg_ack), 32'd0);
    @(negedge CLK);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".vid_data"},  32'(bus.vid_data),  32'h00);
    chk({tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'h00);
    chk({tag, ".dbg_rdata"}, 32'(bus.dbg_rdata), 32'h00);
    chk({tag, ".ready"},     32'(bus.cpu_ready), 32'd1);
    chk({tag, ".ack"},       32'(bus.dbg_ack),   32'd0);
    chk({tag, ".we"},        32'(bus.ram_we),    32'd0);
    chk({tag, ".adr"},       32'(bus.ram_adr),   32'd0);
    chk({tag, ".wdata"},     32'(bus.ram_wdata), 32'h00);
  endtask

  initial begin
    RESET         = 1'b1;
    preload       = 1'b1;
    bus.RAM_en    = 1'b0;
    bus.PROC_en   = 1'b0;
    bus.vid_adr   = '0;
    bus.cpu_cs    = 1'b0;
    bus.cpu_rnw   = 1'b1;
    bus.cpu_adr   = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_rnw   = 1'b1;
    bus.dbg_adr   = '0;
    bus.dbg_wdata = '0;
    m_vid   = 8'h00;
    m_cpu   = 8'h00;
    m_dbg   = 8'h00;
    m_ready = 1'b1;

    repeat (3) @(negedge CLK);
    preload = 1'b0;
    RESET   = 1'b0;
    chk_reset_values("reset");
    @(negedge CLK);

    // Video fetch
    bus.vid_adr = 15'h7C00;
    slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "vid");

    // CPU write then read back
    bus.cpu_cs    = 1'b1;
    bus.cpu_rnw   = 1'b0;
    bus.cpu_adr   = 15'h0123;
    bus.cpu_wdata = 8'h5A;
    slot(1'b0, EX_CPU_WR, 15'h0123, 8'h5A, 1'b1, "cpu_wr");
    bus.cpu_rnw = 1'b1;
    slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "vid2");
    slot(1'b0, EX_CPU_RD, 15'h0123, 8'h5A, 1'b1, "cpu_rd");
    chk("mem_0123", 32'(mem[15'h0123]), 32'h5A);

    // Debug read with idle CPU
    bus.cpu_cs  = 1'b0;
    bus.dbg_req = 1'b1;
    bus.dbg_rnw = 1'b1;
    bus.dbg_adr = 15'h1000;
    slot(1'b0, EX_DBG_RD, 15'h1000, 8'h3C, 1'b1, "dbg_rd");

    // Starvation: CPU keeps four C slots, the fifth is stolen for a debug write
    bus.cpu_cs    = 1'b1;
    bus.cpu_rnw   = 1'b1;
    bus.cpu_adr   = 15'h0123;
    bus.dbg_req   = 1'b1;
    bus.dbg_rnw   = 1'b0;
    bus.dbg_adr   = 15'h0456;
    bus.dbg_wdata = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "starve_v");
      slot(1'b0, EX_CPU_RD, 15'h0123, 8'h5A, 1'b1, $sformatf("starve_cpu%0d", i));
    end
    slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "steal_v");
    slot(1'b0, EX_DBG_WR, 15'h0456, 8'hC3, 1'b0, "steal");
    slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "post_steal_v");
    slot(1'b0, EX_CPU_RD, 15'h0123, 8'h5A, 1'b1, "post_steal_cpu");
    chk("mem_0456", 32'(mem[15'h0456]), 32'hC3);

    // Video slot with a pending debug request: debug waits for slot C
    bus.cpu_cs  = 1'b0;
    bus.vid_adr = 15'h0200;
    bus.dbg_req = 1'b1;
    bus.dbg_rnw = 1'b1;
    bus.dbg_adr = 15'h0456;
    slot(1'b1, EX_VID, 15'h0200, 8'h77, 1'b1, "vid_pending_dbg");
    slot(1'b0, EX_DBG_RD, 15'h0456, 8'hC3, 1'b1, "dbg_after_v");
    slot(1'b0, EX_NONE, 15'h0000, 8'h00, 1'b1, "idle_c");

    // Reset during a CPU write
    bus.cpu_cs    = 1'b1;
    bus.cpu_rnw   = 1'b0;
    bus.cpu_adr   = 15'h0200;
    bus.cpu_wdata = 8'hFF;
    bus.RAM_en    = 1'b1;
    bus.PROC_en   = 1'b0;
    @(negedge CLK);
    bus.RAM_en = 1'b0;
    chk("rst_pre_we", 32'(bus.ram_we), 32'd1);
    RESET = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    bus.cpu_cs = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk("mem_0200_kept", 32'(mem[15'h0200]), 32'h77);
    m_vid   = 8'h00;
    m_cpu   = 8'h00;
    m_dbg   = 8'h00;
    m_ready = 1'b1;
    bus.vid_adr = 15'h7C00;
    slot(1'b1, EX_VID, 15'h7C00, 8'hA5, 1'b1, "post_rst_vid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
